lane_width_adapter: RTL and testbench
=====================================

// Module: lane_width_adapter
// PURPOSE
//   Parametrised multi-channel width adapter with a valid/ready handshake.
//   Converts CH lanes of IN_W bits to OUT_W bits using one of three
//   extension/truncation modes, buffers converted beats in a DEPTH-entry
//   FIFO, and flags every lane whose truncation drops significant bits.
//   Sits between port-connected sub-blocks whose vector widths differ.
// PARAMETERS
//   CH     4  number of lanes
//   IN_W   8  input lane width, >=1
//   OUT_W  4  output lane width, >=1
//   MODE   0  0=zero-extend, 1=sign-extend, 2=replicate bit 0
//   DEPTH  4  FIFO entries, power of 2, >=2
//   CNT_W  8  width of the saturating loss counter
// PORTS
//   clk        in   1                  rising-edge clock
//   rst_n      in   1                  asynchronous active-low reset
//   in_valid   in   1                  input beat valid
//   in_ready   out  1                  input beat accepted when valid&ready
//   in_data    in   [CH-1:0][IN_W-1:0] input lanes
//   out_valid  out  1                  head entry valid
//   out_ready  in   1                  consumer takes head when valid&ready
//   out_data   out  [CH-1:0][OUT_W-1:0] converted lanes at FIFO head
//   out_lossy  out  [CH-1:0]           per-lane loss mask of head entry
//   loss_clr   in   1                  synchronous clear of loss_cnt
//   loss_cnt   out  [CNT_W-1:0]        accepted beats with any lossy lane
//   level      out  [$clog2(DEPTH):0]  current FIFO occupancy
// BEHAVIOUR
//   Reset (rst_n low, async): FIFO emptied; level=0, out_valid=0,
//     out_data=0, out_lossy=0, loss_cnt=0; in_ready=1 (reflects empty).
//   Conversion (done at push, result + mask stored per entry), per lane:
//     OUT_W<=IN_W: out = in[OUT_W-1:0]; lossy when dropped bits
//       in[IN_W-1:OUT_W] are not all equal to: MODE0 zero, MODE1
//       in[OUT_W-1], MODE2 in[0]. OUT_W==IN_W: copy, never lossy.
//     OUT_W>IN_W: upper bits = MODE0 zero, MODE1 in[IN_W-1], MODE2 in[0];
//       never lossy.
//   Handshake: in_ready = (level!=DEPTH). Push on in_valid&in_ready.
//     out_valid = (level!=0). Pop on out_valid&out_ready.
//     in_valid may drop without acceptance; data held stable not required.
//   Latency: beat accepted at edge N is visible on out_* after edge N
//     (one cycle) when FIFO was empty; no combinational in->out path.
//   Ordering: strict FIFO; pointers wrap modulo DEPTH.
//   Simultaneous push+pop: level unchanged, both take effect; at full no
//     push occurs (in_ready=0) even if out_ready=1 that cycle.
//   When empty, out_data/out_lossy hold the last popped entry (0 after reset).
//   loss_cnt: +1 per pushed beat with |lossy, saturates at 2^CNT_W-1;
//     loss_clr has priority: counter becomes 0 even if a lossy push
//     occurs the same cycle.
//   Reset mid-operation discards all buffered beats immediately.
// TESTING (CH=4 IN_W=8 OUT_W=4 DEPTH=4 unless stated)
//   MODE0 push lanes{3..0}={FF,10,0F,05} -> next cycle out_data={F,0,F,5},
//     out_lossy=4'b1100, loss_cnt=1, out_valid=1.
//   MODE1 push lane0=F8 -> 4'h8 not lossy; lane0=08 -> 4'h8 lossy.
//   out_ready=0, push 5 beats: 4 accepted, in_ready=0, level=4; then
//     out_ready=1 pops beats 1..4 in order, one per cycle, level->0.
//   CNT_W=3: 9 lossy pushes -> loss_cnt stays 7; loss_clr with lossy
//     push same cycle -> loss_cnt=0.
//   level=3, assert rst_n=0 mid-cycle -> out_valid=0 and level=0 at once,
//     before next edge; after release first new push emerges alone.
//   IN_W=4 OUT_W=8 MODE2: 4'h1 -> 8'hF1, 4'hE -> 8'h0E, out_lossy=0.

Source files
------------

// File: rtl/lane_width_adapter.sv
// Multi-lane width adapter with a valid/ready handshake. Each input beat is
// converted lane by lane when it is pushed. The converted data and its
// per-lane loss mask are stored together in a small FIFO. A saturating
// counter counts the accepted beats that had at least one lossy lane.

// One lane: resize IN_W -> OUT_W and flag dropped significant bits.
module lane_width_adapter_lane #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int MODE  = 0
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             lossy
);

    generate
        if (OUT_W == IN_W) begin : g_copy
            // Identical widths: pass straight through, nothing can be lost.
            always_comb begin
                dout  = din;
                lossy = 1'b0;
            end
        end else if (OUT_W < IN_W) begin : g_trunc
            logic ref_bit;
            // Truncate. The dropped bits are lossless only if every one of
            // them equals the bit the chosen mode would extend with.
            always_comb begin
                ref_bit = 1'b0;
                if (MODE == 1)
                    ref_bit = din[OUT_W-1];
                else if (MODE == 2)
                    ref_bit = din[0];
                dout  = din[OUT_W-1:0];
                lossy = (din[IN_W-1:OUT_W] != {(IN_W-OUT_W){ref_bit}});
            end
        end else begin : g_extend
            logic ext_bit;
            // Widen. The fill bit depends on the mode. Widening is never lossy.
            always_comb begin
                ext_bit = 1'b0;
                if (MODE == 1)
                    ext_bit = din[IN_W-1];
                else if (MODE == 2)
                    ext_bit = din[0];
                dout  = {{(OUT_W-IN_W){ext_bit}}, din};
                lossy = 1'b0;
            end
        end
    endgenerate

endmodule

// Top: per-lane converters, the entry FIFO, and the loss counter.
module lane_width_adapter #(
    parameter int CH    = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int MODE  = 0,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH-1:0][IN_W-1:0]        in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH-1:0][OUT_W-1:0]       out_data,
    output logic [CH-1:0]                  out_lossy,
    input  logic                           loss_clr,
    output logic [CNT_W-1:0]               loss_cnt,
    output logic [$clog2(DEPTH):0]         level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [CH-1:0][OUT_W-1:0] data;
        logic [CH-1:0]            lossy;
    } entry_t;

    entry_t              conv;
    entry_t              mem [DEPTH];
    entry_t              last;
    entry_t              head;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            lane_width_adapter_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W),
                .MODE  (MODE)
            ) u_lane (
                .din   (in_data[gi]),
                .dout  (conv.data[gi]),
                .lossy (conv.lossy[gi])
            );
        end
    endgenerate

    // The handshake depends only on the stored occupancy. This keeps
    // in_valid off every combinational path to the outputs.
    always_comb begin
        in_ready  = (level != FULL);
        out_valid = (level != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Entry storage. It is not reset because the level register decides
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= conv;
    end

    // Pointers and occupancy. Reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Remember the entry just popped so the outputs hold it while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= '0;
        else if (pop)
            last <= mem[rd_ptr];
    end

    // Show the head entry while the FIFO holds data, else the last one popped.
    always_comb begin
        head      = out_valid ? mem[rd_ptr] : last;
        out_data  = head.data;
        out_lossy = head.lossy;
    end

    // Saturating count of accepted beats with any lossy lane. Clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loss_cnt <= '0;
        else if (loss_clr)
            loss_cnt <= '0;
        else if (push && (|conv.lossy) && (loss_cnt != {CNT_W{1'b1}}))
            loss_cnt <= loss_cnt + 1'b1;
    end

endmodule

// File: tb/tb_lane_width_adapter.sv
// Directed bench for lane_width_adapter. It drives shared inputs into a
// MODE0 instance, a MODE1 instance, a MODE0 instance with a 3-bit counter,
// and a separate widening MODE2 instance (IN_W=4, OUT_W=8).
module tb_lane_width_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, out_ready, loss_clr;
    logic [3:0][7:0] in_data;
    logic [3:0][3:0] in_data3;

    logic in_ready0, in_ready1, in_ready2, in_ready3;
    logic out_valid0, out_valid1, out_valid2, out_valid3;
    logic [3:0][3:0] out_data0, out_data1, out_data2;
    logic [3:0][7:0] out_data3;
    logic [3:0] out_lossy0, out_lossy1, out_lossy2, out_lossy3;
    logic [7:0] loss_cnt0, loss_cnt1, loss_cnt3;
    logic [2:0] loss_cnt2;
    logic [2:0] level0, level1, level2, level3;

    lane_width_adapter #(.MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_lossy(out_lossy0), .loss_clr(loss_clr),
        .loss_cnt(loss_cnt0), .level(level0));

    lane_width_adapter #(.MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_lossy(out_lossy1), .loss_clr(loss_clr),
        .loss_cnt(loss_cnt1), .level(level1));

    lane_width_adapter #(.MODE(0), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_lossy(out_lossy2), .loss_clr(loss_clr),
        .loss_cnt(loss_cnt2), .level(level2));

    lane_width_adapter #(.IN_W(4), .OUT_W(8), .MODE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_lossy(out_lossy3), .loss_clr(loss_clr),
        .loss_cnt(loss_cnt3), .level(level3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] din3;
        logic [15:0] exp_d;
        logic [3:0]  exp_l0;
        logic [3:0]  exp_l1;
        logic [7:0]  exp_c;
        logic [31:0] exp_d3;
    } vec_t;

    vec_t vt[5];

    initial begin
        // Lane order in every literal: {lane3, lane2, lane1, lane0}.
        vt[0] = '{32'hFF100F05, 16'h1E0F, 16'hF0F5, 4'b1100, 4'b0110, 8'd1, 32'hF10E00FF};
        vt[1] = '{32'hF8087087, 16'h2345, 16'h8807, 4'b1011, 4'b0111, 8'd2, 32'h02F304F5};
        vt[2] = '{32'h00FF0AF5, 16'hABCD, 16'h0FA5, 4'b0101, 4'b0011, 8'd3, 32'h0AFB0CFD};
        vt[3] = '{32'h12345678, 16'h0000, 16'h2468, 4'b1111, 4'b1111, 8'd4, 32'h00000000};
        vt[4] = '{32'h01020304, 16'hFFFF, 16'h1234, 4'b0000, 4'b0000, 8'd4, 32'hFFFFFFFF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; loss_clr = 1'b0;
        in_data = '0; in_data3 = '0;
        #12;
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        chk("rst_out_data", 64'(out_data0), 64'd0);
        chk("rst_loss_cnt", 64'(loss_cnt0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: push one beat, check the head one cycle later, then pop it.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = vt[i].din; in_data3 = vt[i].din3; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            chk("vec_out_valid", 64'(out_valid0), 64'd1);
            chk("vec_level", 64'(level0), 64'd1);
            chk("vec_data_m0", 64'(out_data0), 64'(vt[i].exp_d));
            chk("vec_data_m1", 64'(out_data1), 64'(vt[i].exp_d));
            chk("vec_lossy_m0", 64'(out_lossy0), 64'(vt[i].exp_l0));
            chk("vec_lossy_m1", 64'(out_lossy1), 64'(vt[i].exp_l1));
            chk("vec_cnt_m0", 64'(loss_cnt0), 64'(vt[i].exp_c));
            chk("vec_cnt_m1", 64'(loss_cnt1), 64'(vt[i].exp_c));
            chk("vec_data_wide", 64'(out_data3), 64'(vt[i].exp_d3));
            chk("vec_lossy_wide", 64'(out_lossy3), 64'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("vec_pop_level", 64'(level0), 64'd0);
            chk("vec_hold_data", 64'(out_data0), 64'(vt[i].exp_d));
        end
        chk("cnt3_after_table", 64'(loss_cnt2), 64'd4);
        chk("wide_cnt", 64'(loss_cnt3), 64'd0);

        // Fill: five beats offered with out_ready low. Only four are accepted.
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_data = {4{8'(k)}};
            tick();
        end
        chk("full_in_ready", 64'(in_ready0), 64'd0);
        chk("full_level", 64'(level0), 64'd4);
        // Drain. Beat 5 is still offered on the first pop edge and must be refused.
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", 64'(out_data0), 64'({4{4'(k)}}));
            tick();
            in_valid = 1'b0;
            chk("drain_level", 64'(level0), 64'(4 - k));
        end
        chk("drain_out_valid", 64'(out_valid0), 64'd0);
        chk("drain_hold", 64'(out_data0), 64'h4444);
        out_ready = 1'b0;

        // Push and pop in the same cycle leave the level unchanged.
        in_valid = 1'b1; in_data = {4{8'h09}};
        tick();
        in_data = {4{8'h0A}}; out_ready = 1'b1;
        tick();
        chk("pushpop_level", 64'(level0), 64'd1);
        chk("pushpop_data", 64'(out_data0), 64'hAAAA);
        in_valid = 1'b0;
        tick();
        chk("pushpop_drain", 64'(level0), 64'd0);

        // Saturation: nine lossy pushes. The 3-bit counter stops at 7.
        in_valid = 1'b1; in_data = {4{8'hFF}}; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("sat_cnt3", 64'(loss_cnt2), 64'd7);
        chk("sat_cnt8", 64'(loss_cnt0), 64'd13);
        loss_clr = 1'b1;
        tick();
        loss_clr = 1'b0; in_valid = 1'b0;
        chk("clr_cnt3", 64'(loss_cnt2), 64'd0);
        chk("clr_cnt8", 64'(loss_cnt0), 64'd0);
        tick();
        chk("clr_drain", 64'(level0), 64'd0);
        out_ready = 1'b0;

        // Asynchronous reset with three beats buffered.
        in_valid = 1'b1;
        for (int k = 11; k <= 13; k++) begin
            in_data = {4{8'(k)}};
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 64'(level0), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_level", 64'(level0), 64'd0);
        chk("async_out_valid", 64'(out_valid0), 64'd0);
        chk("async_out_data", 64'(out_data0), 64'd0);
        chk("async_in_ready", 64'(in_ready0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = {4{8'h0E}};
        tick();
        in_valid = 1'b0;
        chk("post_rst_level", 64'(level0), 64'd1);
        chk("post_rst_data", 64'(out_data0), 64'hEEEE);
        out_ready = 1'b1;
        tick();
        chk("post_rst_drain", 64'(level0), 64'd0);
        chk("post_rst_empty", 64'(out_valid0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
